hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage RV32I core. It drives the bubble/flush inputs of every inter-stage segment register (IF/ID through MEM/WB) and the EX-stage forwarding muxes. It sequences data-cache miss stalls with a registered miss FSM and a timeout watchdog. It sits beside the datapath and consumes register indices, write enables and branch/miss status from the stages.

---
 rtl/hazard_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall controller for the 5-stage RV32I core.
// Drives bubble/flush of every segment register and the EX forwarding
// muxes, and tracks D-cache miss stalls with an FSM plus a sticky
// timeout watchdog.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating
// stall/flush performance counters; otherwise both are tied to zero.
module hazard_ctrl #(
    parameter int MISS_TIMEOUT = 256,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       reg1_srcD,
    input  logic [4:0]       reg2_srcD,
    input  logic [4:0]       reg1_srcE,
    input  logic [4:0]       reg2_srcE,
    input  logic [4:0]       reg_dstE,
    input  logic [4:0]       reg_dstM,
    input  logic [4:0]       reg_dstW,
    input  logic             load_en_E,
    input  logic             reg_write_en_MEM,
    input  logic             reg_write_en_WB,
    input  logic             br_E,
    input  logic             jalr_E,
    input  logic             jal_D,
    input  logic             dcache_miss,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [1:0]       op1_sel,
    output logic [1:0]       op2_sel,
    output logic             miss_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TW = $clog2(MISS_TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(MISS_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tmo_cnt;

    logic miss_stall;
    logic cf_ex;
    logic load_use;

    // Forwarding select for one EX operand; MEM beats WB, x0 never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       we_m,
        input logic [4:0] dst_m,
        input logic       we_w,
        input logic [4:0] dst_w
    );
        if (we_m && (dst_m != 5'd0) && (dst_m == src))
            return 2'b01;
        else if (we_w && (dst_w != 5'd0) && (dst_w == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // The stall follows the live miss line: in MISS the FSM only leaves when
    // dcache_miss drops, and that exit cycle already runs unstalled, so the
    // registered state adds nothing beyond dcache_miss itself.
    assign miss_stall = dcache_miss;
    assign cf_ex      = br_E | jalr_E;
    assign load_use   = load_en_E && (reg_dstE != 5'd0) &&
                        ((reg_dstE == reg1_srcD) || (reg_dstE == reg2_srcD));

    // Miss FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Miss FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dcache_miss)  state_nxt = S_MISS;
            S_MISS:  if (!dcache_miss) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Watchdog: counts MISS cycles, saturates, and latches the sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt      <= '0;
            miss_timeout <= 1'b0;
        end else if ((state == S_IDLE) && dcache_miss) begin
            tmo_cnt <= '0;
        end else if (state == S_MISS) begin
            if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_MAX)
                miss_timeout <= 1'b1;
        end
    end

    // Output decode in priority order: reset, miss, control flow, load-use.
    always_comb begin
        bubbleF = 1'b0;
        bubbleD = 1'b0;
        bubbleE = 1'b0;
        bubbleM = 1'b0;
        bubbleW = 1'b0;
        flushF  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        flushW  = 1'b0;
        op1_sel = 2'b00;
        op2_sel = 2'b00;
        if (rst) begin
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (miss_stall) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            bubbleM = 1'b1;
            flushW  = 1'b1;
        end else begin
            op1_sel = fwd_sel(reg1_srcE, reg_write_en_MEM, reg_dstM,
                              reg_write_en_WB, reg_dstW);
            op2_sel = fwd_sel(reg2_srcE, reg_write_en_MEM, reg_dstM,
                              reg_write_en_WB, reg_dstW);
            if (cf_ex) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (jal_D) begin
                flushD = 1'b1;
            end else if (load_use) begin
                bubbleF = 1'b1;
                bubbleD = 1'b1;
                flushE  = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Performance counters; flushD is only set by control flow outside reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bubbleF)
                stall_cnt <= sat_inc(stall_cnt);
            if (flushD)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
